// File: rtl/alu_pkg.sv
// alu_pkg: ALU op codes, main-control alu_op encodings and R-type funct values
package alu_pkg;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [1:0] AOP_ADD   = 2'b00;
  localparam logic [1:0] AOP_SUB   = 2'b01;
  localparam logic [1:0] AOP_FUNCT = 2'b10;
  localparam logic [1:0] AOP_OR    = 2'b11;
  localparam logic [5:0] FUNCT_ADD  = 6'b100000;
  localparam logic [5:0] FUNCT_ADDU = 6'b100001;
  localparam logic [5:0] FUNCT_SUB  = 6'b100010;
  localparam logic [5:0] FUNCT_SUBU = 6'b100011;
  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_NOR  = 6'b100111;
  localparam logic [5:0] FUNCT_SLT  = 6'b101010;
endpackage

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: maps alu_op/funct to the 4-bit ALU op and flags undecodable funct
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] alu_ctrl,
  output logic       illegal
);
  logic [3:0] f_ctrl;
  logic       f_ill;
  always_comb begin
    f_ctrl = ALU_ADD;
    f_ill  = 1'b0;
    case (funct)
      FUNCT_ADD, FUNCT_ADDU: f_ctrl = ALU_ADD;
      FUNCT_SUB, FUNCT_SUBU: f_ctrl = ALU_SUB;
      FUNCT_AND:             f_ctrl = ALU_AND;
      FUNCT_OR:              f_ctrl = ALU_OR;
      FUNCT_NOR:             f_ctrl = ALU_NOR;
      FUNCT_SLT:             f_ctrl = ALU_SLT;
      default:               f_ill  = 1'b1;
    endcase
    alu_ctrl = alu_op == AOP_FUNCT ? f_ctrl :
               alu_op == AOP_SUB   ? ALU_SUB :
               alu_op == AOP_OR    ? ALU_OR  : ALU_ADD;
    illegal  = alu_op == AOP_FUNCT && f_ill;
  end
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID/EX slot with ALU decode, EX/MEM>MEM/WB forwarding, imm mux, valid/ready, flush
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int W  = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [RW-1:0] rs_idx,
  input  logic [RW-1:0] rt_idx,
  input  logic [RW-1:0] rd_idx,
  input  logic [W-1:0]  rs_data,
  input  logic [W-1:0]  rt_data,
  input  logic [15:0]   imm16,
  input  logic          zero_ext,
  input  logic          alu_src,
  input  logic [1:0]    alu_op,
  input  logic [5:0]    funct,
  input  logic          exmem_wr,
  input  logic          memwb_wr,
  input  logic [RW-1:0] exmem_rd,
  input  logic [RW-1:0] memwb_rd,
  input  logic [W-1:0]  exmem_data,
  input  logic [W-1:0]  memwb_data,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  alu_a,
  output logic [W-1:0]  alu_b,
  output logic [3:0]    alu_ctrl,
  output logic [W-1:0]  store_data,
  output logic [RW-1:0] dest,
  output logic          illegal
);
  logic [3:0]    dec_ctrl;
  logic          dec_ill;
  logic          cap;
  logic [W-1:0]  fwd_rs, fwd_rt, ext;
  logic          valid_q, valid_d, ill_q, ill_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, sd_q, sd_d;
  logic [3:0]    ctrl_q, ctrl_d;
  logic [RW-1:0] dest_q, dest_d;
  alu_ctrl_decode u_dec (
    .alu_op   (alu_op),
    .funct    (funct),
    .alu_ctrl (dec_ctrl),
    .illegal  (dec_ill)
  );
  always_comb begin
    in_ready = !valid_q || out_ready;
    cap      = in_valid && in_ready && !flush;
    fwd_rs   = exmem_wr && exmem_rd == rs_idx && rs_idx != '0 ? exmem_data :
               memwb_wr && memwb_rd == rs_idx && rs_idx != '0 ? memwb_data : rs_data;
    fwd_rt   = exmem_wr && exmem_rd == rt_idx && rt_idx != '0 ? exmem_data :
               memwb_wr && memwb_rd == rt_idx && rt_idx != '0 ? memwb_data : rt_data;
    ext      = zero_ext ? {{(W-16){1'b0}}, imm16} : {{(W-16){imm16[15]}}, imm16};
    valid_d  = flush ? 1'b0 : cap || (valid_q && !out_ready);
    a_d      = cap ? fwd_rs : a_q;
    b_d      = cap ? (alu_src ? ext : fwd_rt) : b_q;
    sd_d     = cap ? fwd_rt : sd_q;
    ctrl_d   = cap ? dec_ctrl : ctrl_q;
    dest_d   = cap ? rd_idx : dest_q;
    ill_d    = cap ? dec_ill : ill_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sd_q    <= '0;
      ctrl_q  <= ALU_ADD;
      dest_q  <= '0;
      ill_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sd_q    <= sd_d;
      ctrl_q  <= ctrl_d;
      dest_q  <= dest_d;
      ill_q   <= ill_d;
    end
  end
  assign out_valid  = valid_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign store_data = sd_q;
  assign alu_ctrl   = ctrl_q;
  assign dest       = dest_q;
  assign illegal    = ill_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed and randomized checks of alu_issue_stage against a slot-level model
module tb_alu_issue_stage;
  logic        clk = 1'b0, rst;
  logic        in_valid, in_ready, zero_ext, alu_src, exmem_wr, memwb_wr, flush;
  logic        out_valid, out_ready, illegal;
  logic [4:0]  rs_idx, rt_idx, rd_idx, exmem_rd, memwb_rd, dest;
  logic [31:0] rs_data, rt_data, exmem_data, memwb_data, alu_a, alu_b, store_data;
  logic [15:0] imm16;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic [3:0]  alu_ctrl;
  int n_chk = 0, n_fail = 0;
  logic        m_valid, m_ill;
  logic [31:0] m_a, m_b, m_sd;
  logic [3:0]  m_ctrl;
  logic [4:0]  m_dest;
  logic [4:0]  ftab [64];
  logic [5:0]  legal [8];
  always #5 clk = ~clk;
  alu_issue_stage #(.W(32), .RW(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .rs_idx(rs_idx), .rt_idx(rt_idx), .rd_idx(rd_idx), .rs_data(rs_data), .rt_data(rt_data),
    .imm16(imm16), .zero_ext(zero_ext), .alu_src(alu_src), .alu_op(alu_op), .funct(funct),
    .exmem_wr(exmem_wr), .memwb_wr(memwb_wr), .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
    .exmem_data(exmem_data), .memwb_data(memwb_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .alu_a(alu_a), .alu_b(alu_b),
    .alu_ctrl(alu_ctrl), .store_data(store_data), .dest(dest), .illegal(illegal)
  );
  function automatic logic [31:0] fw(input logic [4:0] idx, input logic [31:0] rf);
    if (idx == 5'd0) return rf;
    if (exmem_wr && exmem_rd == idx) return exmem_data;
    if (memwb_wr && memwb_rd == idx) return memwb_data;
    return rf;
  endfunction
  task automatic model_reset;
    m_valid = 0; m_a = 0; m_b = 0; m_sd = 0; m_ctrl = 4'b0010; m_dest = 0; m_ill = 0;
  endtask
  task automatic tick;
    logic [4:0] t;
    if (flush) m_valid = 0;
    else if (in_valid && (!m_valid || out_ready)) begin
      t = alu_op == 2'b10 ? ftab[funct] :
          {1'b0, alu_op == 2'b00 ? 4'b0010 : alu_op == 2'b01 ? 4'b0110 : 4'b0001};
      m_valid = 1;
      m_a     = fw(rs_idx, rs_data);
      m_sd    = fw(rt_idx, rt_data);
      m_b     = alu_src ? (zero_ext ? {16'h0, imm16} : {{16{imm16[15]}}, imm16}) : m_sd;
      m_ctrl  = t[3:0];
      m_ill   = t[4];
      m_dest  = rd_idx;
    end else if (out_ready) m_valid = 0;
    @(posedge clk);
    #1;
  endtask
  task automatic idle;
    in_valid = 0; flush = 0; out_ready = 1; exmem_wr = 0; memwb_wr = 0;
    exmem_rd = 0; memwb_rd = 0; exmem_data = 0; memwb_data = 0;
    rs_idx = 0; rt_idx = 0; rd_idx = 0; rs_data = 0; rt_data = 0;
    imm16 = 0; zero_ext = 0; alu_src = 0; alu_op = 0; funct = 0;
  endtask
  task automatic insn(input logic [4:0] rs, rt, rd, input logic [31:0] rsd, rtd,
                      input logic [15:0] imm, input logic zx, src, input logic [1:0] aop,
                      input logic [5:0] fn);
    rs_idx = rs; rt_idx = rt; rd_idx = rd; rs_data = rsd; rt_data = rtd;
    imm16 = imm; zero_ext = zx; alu_src = src; alu_op = aop; funct = fn;
  endtask
  task automatic test_reset;
    idle();
    rst = 1;
    #1;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_chk++; if (alu_ctrl !== 4'b0010) begin n_fail++; $display("FAIL reset_ctrl got %b want 0010", alu_ctrl); end
    n_chk++; if ({alu_a, alu_b, store_data, dest, illegal} !== '0) begin n_fail++;
      $display("FAIL reset_data got a=%h b=%h sd=%h dest=%0d ill=%b want 0", alu_a, alu_b, store_data, dest, illegal); end
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask
  task automatic test_rtype_sub;
    idle();
    insn(1, 2, 3, 10, 3, 0, 0, 0, 2'b10, 6'b100010);
    in_valid = 1;
    tick();
    in_valid = 0;
    n_chk++; if ({out_valid, alu_ctrl, alu_a, alu_b, illegal, dest} !== {1'b1, 4'b0110, 32'd10, 32'd3, 1'b0, 5'd3}) begin n_fail++;
      $display("FAIL rtype_sub got v=%b ctrl=%b a=%0d b=%0d ill=%b dest=%0d want v=1 ctrl=0110 a=10 b=3 ill=0 dest=3",
               out_valid, alu_ctrl, alu_a, alu_b, illegal, dest); end
    tick();
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drain got %b want 0", out_valid); end
  endtask
  task automatic test_forwarding;
    logic [31:0] want [3];
    want[0] = 32'hAAAA; want[1] = 32'hBBBB; want[2] = 32'h1234;
    for (int i = 0; i < 3; i++) begin
      idle();
      insn(i == 2 ? 5'd0 : 5'd5, i == 2 ? 5'd0 : 5'd5, 7, 32'h1234, 32'h1234, 0, 0, 0, 2'b00, 0);
      exmem_wr = i != 1; memwb_wr = 1;
      exmem_rd = i == 2 ? 5'd0 : 5'd5; memwb_rd = exmem_rd;
      exmem_data = 32'hAAAA; memwb_data = 32'hBBBB;
      in_valid = 1;
      tick();
      in_valid = 0;
      n_chk++; if (alu_a !== want[i]) begin n_fail++; $display("FAIL fwd_rs case %0d got %h want %h", i, alu_a, want[i]); end
      n_chk++; if (store_data !== want[i]) begin n_fail++; $display("FAIL fwd_rt case %0d got %h want %h", i, store_data, want[i]); end
      tick();
    end
  endtask
  task automatic test_immediates;
    idle();
    insn(1, 2, 4, 5, 32'h77, 16'hFFFF, 0, 1, 2'b00, 0);
    in_valid = 1;
    tick();
    n_chk++; if ({alu_b, alu_ctrl, store_data} !== {32'hFFFFFFFF, 4'b0010, 32'h77}) begin n_fail++;
      $display("FAIL imm_sext got b=%h ctrl=%b sd=%h want ffffffff 0010 77", alu_b, alu_ctrl, store_data); end
    zero_ext = 1; alu_op = 2'b11;
    tick();
    in_valid = 0;
    n_chk++; if ({alu_b, alu_ctrl, illegal} !== {32'h0000FFFF, 4'b0001, 1'b0}) begin n_fail++;
      $display("FAIL imm_zext got b=%h ctrl=%b ill=%b want 0000ffff 0001 0", alu_b, alu_ctrl, illegal); end
    tick();
  endtask
  task automatic test_stall_flush;
    idle();
    out_ready = 0;
    insn(1, 1, 9, 32'h11, 32'h22, 0, 0, 0, 2'b00, 0);
    in_valid = 1;
    tick();
    insn(2, 2, 10, 32'h99, 32'h98, 0, 0, 0, 2'b01, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready cycle %0d got %b want 0", i, in_ready); end
      tick();
      n_chk++; if ({out_valid, alu_a, store_data, dest, alu_ctrl} !== {1'b1, 32'h11, 32'h22, 5'd9, 4'b0010}) begin n_fail++;
        $display("FAIL stall_hold cycle %0d got v=%b a=%h sd=%h dest=%0d ctrl=%b want 1 11 22 9 0010",
                 i, out_valid, alu_a, store_data, dest, alu_ctrl); end
    end
    flush = 1;
    tick();
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_held got %b want 0", out_valid); end
    out_ready = 1;
    #1;
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready got %b want 1", in_ready); end
    tick();
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_beats_capture got %b want 0", out_valid); end
    flush = 0; in_valid = 0;
    tick();
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_capture got %b want 0", out_valid); end
  endtask
  task automatic test_illegal;
    idle();
    insn(1, 2, 3, 1, 2, 0, 0, 0, 2'b10, 6'b000000);
    in_valid = 1;
    tick();
    n_chk++; if ({out_valid, alu_ctrl, illegal} !== {1'b1, 4'b0010, 1'b1}) begin n_fail++;
      $display("FAIL illegal_sll got v=%b ctrl=%b ill=%b want 1 0010 1", out_valid, alu_ctrl, illegal); end
    alu_op = 2'b00;
    tick();
    in_valid = 0;
    n_chk++; if ({out_valid, alu_ctrl, illegal} !== {1'b1, 4'b0010, 1'b0}) begin n_fail++;
      $display("FAIL illegal_nonfunct got v=%b ctrl=%b ill=%b want 1 0010 0", out_valid, alu_ctrl, illegal); end
    tick();
  endtask
  task automatic test_back_to_back;
    idle();
    in_valid = 1;
    for (int i = 0; i < 8; i++) begin
      insn(3, 4, 5'(i), 32'(100 + i), 32'(i), 0, 0, 0, 2'b10, legal[i]);
      #1;
      n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready beat %0d got %b want 1", i, in_ready); end
      tick();
      n_chk++; if ({out_valid, alu_a, dest, alu_ctrl} !== {1'b1, 32'(100 + i), 5'(i), ftab[legal[i]][3:0]}) begin n_fail++;
        $display("FAIL b2b beat %0d got v=%b a=%0d dest=%0d ctrl=%b want 1 %0d %0d %b",
                 i, out_valid, alu_a, dest, alu_ctrl, 100 + i, i, ftab[legal[i]][3:0]); end
    end
    in_valid = 0;
    tick();
  endtask
  task automatic test_random;
    for (int i = 0; i < 400; i++) begin
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      flush = $urandom_range(0, 9) == 0;
      insn(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom), $urandom, $urandom,
           16'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
           $urandom_range(0, 3) == 0 ? 6'($urandom) : legal[$urandom_range(0, 7)]);
      exmem_wr = 1'($urandom); memwb_wr = 1'($urandom);
      exmem_rd = 5'($urandom_range(0, 3)); memwb_rd = 5'($urandom_range(0, 3));
      exmem_data = $urandom; memwb_data = $urandom;
      #1;
      n_chk++; if (in_ready !== (!m_valid || out_ready)) begin n_fail++;
        $display("FAIL rand_in_ready iter %0d got %b want %b", i, in_ready, !m_valid || out_ready); end
      tick();
      n_chk++; if (out_valid !== m_valid) begin n_fail++; $display("FAIL rand_valid iter %0d got %b want %b", i, out_valid, m_valid); end
      if (m_valid) begin
        n_chk++; if ({alu_a, alu_b, store_data, alu_ctrl, dest, illegal} !== {m_a, m_b, m_sd, m_ctrl, m_dest, m_ill}) begin n_fail++;
          $display("FAIL rand_slot iter %0d got a=%h b=%h sd=%h ctrl=%b dest=%0d ill=%b want a=%h b=%h sd=%h ctrl=%b dest=%0d ill=%b",
                   i, alu_a, alu_b, store_data, alu_ctrl, dest, illegal, m_a, m_b, m_sd, m_ctrl, m_dest, m_ill); end
      end
    end
    idle();
    tick();
  endtask
  task automatic test_reset_mid_hold;
    idle();
    out_ready = 0;
    insn(6, 7, 8, 32'h5555, 32'h6666, 0, 0, 0, 2'b01, 0);
    in_valid = 1;
    tick();
    in_valid = 0;
    n_chk++; if ({out_valid, alu_ctrl} !== {1'b1, 4'b0110}) begin n_fail++;
      $display("FAIL hold_before_reset got v=%b ctrl=%b want 1 0110", out_valid, alu_ctrl); end
    #2;
    rst = 1;
    #1;
    n_chk++; if ({out_valid, alu_ctrl, alu_a, dest} !== {1'b0, 4'b0010, 32'h0, 5'd0}) begin n_fail++;
      $display("FAIL reset_mid_hold got v=%b ctrl=%b a=%h dest=%0d want 0 0010 0 0", out_valid, alu_ctrl, alu_a, dest); end
    #1;
    rst = 0;
    model_reset();
    tick();
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL after_reset_valid got %b want 0", out_valid); end
  endtask
  initial begin
    for (int i = 0; i < 64; i++) ftab[i] = 5'b10010;
    ftab[6'b100000] = 5'b00010; ftab[6'b100001] = 5'b00010;
    ftab[6'b100010] = 5'b00110; ftab[6'b100011] = 5'b00110;
    ftab[6'b100100] = 5'b00000; ftab[6'b100101] = 5'b00001;
    ftab[6'b100111] = 5'b01100; ftab[6'b101010] = 5'b00111;
    legal[0] = 6'b100000; legal[1] = 6'b100001; legal[2] = 6'b100010; legal[3] = 6'b100011;
    legal[4] = 6'b100100; legal[5] = 6'b100101; legal[6] = 6'b100111; legal[7] = 6'b101010;
    test_reset();
    test_rtype_sub();
    test_forwarding();
    test_immediates();
    test_stall_flush();
    test_illegal();
    test_back_to_back();
    test_random();
    test_reset_mid_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
ID/EX stage that feeds the 32-bit ALU (op codes: 0000 and, 0001 or, 0010 add, 0110 sub, 0111 slt, 1100 nor). It decodes main-control alu_op plus funct into the 4-bit ALU op, resolves operands with EX/MEM and MEM/WB forwarding, and applies the immediate mux. The result is registered as one pipeline slot with a valid/ready handshake, flush and stall. ALU inputs come straight from this block's registers.

Parameters:
W, 32, datapath width
RW, 5, register index width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  ID presents an instruction
in_ready  out  1  stage can accept this cycle
rs_idx, rt_idx, rd_idx  in  RW each  source and destination indices
rs_data, rt_data  in  W each  register-file read data
imm16  in  16  instruction immediate
zero_ext  in  1  1 = zero-extend imm16 (andi/ori), 0 = sign-extend
alu_src  in  1  1 = operand B is the extended immediate
alu_op  in  2  00 add, 01 sub, 10 use funct, 11 or-immediate
funct  in  6  R-type funct field
exmem_wr, memwb_wr  in  1 each  forwarding-source write enables
exmem_rd, memwb_rd  in  RW each  forwarding-source destinations
exmem_data, memwb_data  in  W each  forwarding-source values
flush  in  1  squash the held/incoming slot (branch taken)
out_valid  out  1  ALU slot valid
out_ready  in  1  EX consumes the slot this cycle
alu_a, alu_b  out  W each  registered ALU operands (inp1, inp2)
alu_ctrl  out  4  registered ALU op
store_data  out  W  forwarded rt value (for sw)
dest  out  RW  registered destination index
illegal  out  1  registered: funct not decodable

Behaviour:
- Reset (async, immediate): out_valid=0, alu_a=alu_b=store_data=0, alu_ctrl=4'b0010, dest=0, illegal=0.
- in_ready = !out_valid | out_ready (combinational; single slot, no skid buffer).
- Capture on a clk edge when in_valid & in_ready & !flush. Latency: one cycle, in to out_valid.
- Hold: out_valid & !out_ready → all outputs stable; in_ready=0.
- Drain without capture: out_valid clears on the edge where out_ready=1 and no new capture.
- Flush: out_valid=0 on the next edge and any same-cycle input is dropped; flush beats capture. Data registers need not clear.
- Forwarding per source (rs, rt), evaluated on the unregistered inputs:
  - EX/MEM wins if exmem_wr and exmem_rd==idx and idx!=0.
  - Otherwise MEM/WB under the same rule.
  - Otherwise register-file data.
  - Index 0 never forwards, so $zero stays 0.
- Immediate: ext = zero_ext ? {16'b0,imm16} : {{16{imm16[15]}},imm16}.
- Operands: alu_a = fwd_rs; alu_b = alu_src ? ext : fwd_rt; store_data = fwd_rt always.
- alu_ctrl decode: alu_op 00→0010, 01→0110, 11→0001.
- alu_op 10 maps funct:
  - 100000/100001→0010
  - 100010/100011→0110
  - 100100→0000
  - 100101→0001
  - 100111→1100
  - 101010→0111
  - Any other funct → alu_ctrl 0010 with illegal=1. The slot is still valid; the trap decision is made downstream.
- illegal is 0 for alu_op != 10.
- Reset mid-hold discards the slot; no partial state survives.

Decomposition:
- Shared package alu_pkg:
  - ALU op constants: ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR.
  - alu_op encodings: AOP_ADD, AOP_SUB, AOP_FUNCT, AOP_OR.
  - FUNCT_* constants.
- One combinational sub-module alu_ctrl_decode (alu_op, funct → alu_ctrl, illegal). It is shared with any future multicycle controller.
- Forwarding muxes and the pipeline register stay in the top module.

Test Plan:
- Reset during out_valid=1: assert rst mid-cycle → out_valid=0 and alu_ctrl=0010 immediately, before the next edge.
- R-type sub: funct=100010, rs_data=10, rt_data=3, alu_op=10 → next cycle alu_ctrl=0110, alu_a=10, alu_b=3, out_valid=1, illegal=0.
- Forwarding priority: rs_idx=5, exmem_rd=5 (data 0xAAAA), memwb_rd=5 (data 0xBBBB), both wr=1 → alu_a=0xAAAA. Repeat with exmem_wr=0 → 0xBBBB. Repeat with rs_idx=0 and both rd=0 → rs_data.
- Immediates: imm16=0xFFFF, alu_src=1, zero_ext=0 → alu_b=0xFFFFFFFF. zero_ext=1 with alu_op=11 → alu_b=0x0000FFFF, alu_ctrl=0001.
- Stall then flush: out_ready=0 for 3 cycles with in_valid=1 → in_ready=0 and outputs frozen. Then flush=1 with in_valid=1 → next cycle out_valid=0 and the input is not captured.
- Illegal funct 000000 (sll) → alu_ctrl=0010, illegal=1, out_valid=1. Back-to-back accepts with out_ready=1 held → one slot per cycle, no bubbles.
